vga_timing_gen: RTL and testbench

//  Generates the 640x480@60 Hz VGA raster. Drives the pixel-coordinate buses hsync/vsync that feed every

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_wrap_counter.sv | 34 +++
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and helpers for the timing generator and the renderers.
package vga_pkg;

    // Coordinate bus width seen by every renderer.
    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    // Default 640x480@60 Hz timing, in pixels and lines.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic [23:0] COLOUR_BLACK = 24'h000000;

    // True when coord lies in the inclusive window [lo, hi].
    function automatic logic in_window(input logic [COORD_W-1:0] coord,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (coord >= lo) && (coord <= hi);
    endfunction

endpackage

// File: rtl/vga_wrap_counter.sv
// Enable-gated counter 0..MAX that wraps to 0; wrap flags the enabled MAX cycle.
module vga_wrap_counter #(
    parameter int MAX = 799,
    parameter int W   = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_q, count_d;

    assign wrap  = en && (count_q == MAX_C);
    assign count = count_q;

    // Next count: advance on enable, fold MAX back to zero.
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = (count_q == MAX_C) ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, H/V coordinate counters and the
// registered DAC output stage (colour, blanking, sync) aligned one pixel behind.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [23:0]        rgb_in,
    output logic [COORD_W-1:0] hsync,
    output logic [COORD_W-1:0] vsync,
    output logic               video_on,
    output logic               pix_en,
    output logic               frame_tick,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOT > COORD_LIMIT || V_TOT > COORD_LIMIT) begin : g_bad_total
        $error("vga_timing_gen: H/V total exceeds coordinate range");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end

    logic        vga_clk_d;
    logic        h_wrap, v_wrap;
    logic [23:0] rgb_q, rgb_d;
    logic        blank_n_q, hs_q, hs_d, vs_q, vs_d, vga_clk_q;

    if (CLK_DIV == 1) begin : g_no_div
        assign pix_en    = 1'b1;
        assign vga_clk_d = 1'b1;
    end else begin : g_div
        localparam int             DIV_W    = $clog2(CLK_DIV);
        localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
        localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

        logic [DIV_W-1:0] div_q, div_d;

        assign pix_en    = (div_q == DIV_LAST);
        assign div_d     = pix_en ? '0 : div_q + DIV_W'(1);
        // Registering the next-divider compare puts the vga_clk rising edge mid-pixel.
        assign vga_clk_d = (div_d >= DIV_HALF);

        // Pixel divider.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) div_q <= '0;
            else        div_q <= div_d;
        end
    end

    vga_wrap_counter #(.MAX(H_TOT - 1), .W(COORD_W)) u_hcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .count (hsync),
        .wrap  (h_wrap)
    );

    vga_wrap_counter #(.MAX(V_TOT - 1), .W(COORD_W)) u_vcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (h_wrap && pix_en),
        .count (vsync),
        .wrap  (v_wrap)
    );

    assign video_on   = (hsync < H_ACT_C) && (vsync < V_ACT_C);
    assign frame_tick = h_wrap && v_wrap;

    assign rgb_d = video_on ? rgb_in : COLOUR_BLACK;
    assign hs_d  = in_window(hsync, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
    assign vs_d  = in_window(vsync, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;

    // DAC output stage: loads once per pixel, one pixel behind the coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q     <= COLOUR_BLACK;
            blank_n_q <= 1'b0;
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            vga_clk_q <= 1'b0;
        end else begin
            vga_clk_q <= vga_clk_d;
            if (pix_en) begin
                rgb_q     <= rgb_d;
                blank_n_q <= video_on;
                hs_q      <= hs_d;
                vs_q      <= vs_d;
            end
        end
    end

    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign vga_blank_n = blank_n_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_clk     = vga_clk_q;
    assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 4;
    localparam int V_ACTIVE = 6,  V_FP = 1, V_SYNC = 2, V_BP = 3;
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 25
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 12
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;         // 600

    typedef struct {
        logic [23:0] rgb;
        logic        blank_n;
        logic        hs;
        logic        vs;
        int          line;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] rgb_in = 24'h0;
    logic [9:0]  hsync, vsync;
    logic        video_on, pix_en, frame_tick, vga_hs, vga_vs;
    logic        vga_blank_n, vga_sync_n, vga_clk;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
        .hsync(hsync), .vsync(vsync), .video_on(video_on), .pix_en(pix_en),
        .frame_tick(frame_tick), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    int   tick_q[$];
    bit   pop_now = 0;
    int   mdiv = 0, mh = 0, mv = 0;
    int   cyc = 0;
    int   rgb_mode = 0;        // 0: constant yellow, 1: random
    int   line0_hs_low = 0;
    bit   first_frame = 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mdiv = 0; mh = 0; mv = 0;
        sb.delete();
        pop_now = 0;
    endtask

    // Check the current negedge state against the model, push the next output, advance the model.
    task automatic sample_and_model();
        exp_t e;
        bit   exp_pix;
        bit   exp_vid;
        exp_pix = (mdiv == CLK_DIV - 1);
        exp_vid = (mh < H_ACTIVE) && (mv < V_ACTIVE);

        if (pop_now) begin
            if (sb.size() == 0) begin
                chk_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk_eq("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
                chk_eq("vga_blank_n", 32'(vga_blank_n), 32'(e.blank_n));
                chk_eq("vga_hs", 32'(vga_hs), 32'(e.hs));
                chk_eq("vga_vs", 32'(vga_vs), 32'(e.vs));
                if (first_frame && e.line == 0 && vga_hs == 1'b0) line0_hs_low++;
            end
            pop_now = 0;
        end

        chk_eq("pix_en", 32'(pix_en), 32'(exp_pix));
        chk_eq("hsync", 32'(hsync), 32'(mh));
        chk_eq("vsync", 32'(vsync), 32'(mv));
        chk_eq("video_on", 32'(video_on), 32'(exp_vid));
        chk_eq("frame_tick", 32'(frame_tick), 32'(exp_pix && mh == HT - 1 && mv == VT - 1));
        chk_eq("vga_clk", 32'(vga_clk), 32'(mdiv >= CLK_DIV / 2));
        chk_eq("vga_sync_n", 32'(vga_sync_n), 32'd0);

        if (frame_tick) tick_q.push_back(cyc);

        if (exp_pix) begin
            rgb_in = (rgb_mode == 0) ? 24'hFFFF00 : 24'($urandom);
            e.rgb     = exp_vid ? rgb_in : 24'h0;
            e.blank_n = exp_vid;
            e.hs      = !((mh >= H_ACTIVE + H_FP) && (mh < H_ACTIVE + H_FP + H_SYNC));
            e.vs      = !((mv >= V_ACTIVE + V_FP) && (mv < V_ACTIVE + V_FP + V_SYNC));
            e.line    = mv;
            sb.push_back(e);
            pop_now = 1;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            mdiv = 0;
        end else begin
            mdiv = mdiv + 1;
        end
    endtask

    task automatic run_clks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_and_model();
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk_eq({pfx, "_hsync"}, 32'(hsync), 32'd0);
        chk_eq({pfx, "_vsync"}, 32'(vsync), 32'd0);
        chk_eq({pfx, "_vga_hs"}, 32'(vga_hs), 32'd1);
        chk_eq({pfx, "_vga_vs"}, 32'(vga_vs), 32'd1);
        chk_eq({pfx, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk_eq({pfx, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        chk_eq({pfx, "_frame_tick"}, 32'(frame_tick), 32'd0);
        chk_eq({pfx, "_pix_en"}, 32'(pix_en), 32'd0);
        chk_eq({pfx, "_vga_clk"}, 32'(vga_clk), 32'd0);
        chk_eq({pfx, "_video_on"}, 32'(video_on), 32'd1);
    endtask

    initial begin
        int base;
        int budget;

        // Reset hold for 10 clocks.
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        model_reset();

        // Two frames: yellow first, random colour second.
        base = cyc;
        tick_q.delete();
        rgb_mode = 0;
        run_clks(FRAME_CLKS);
        first_frame = 0;
        rgb_mode = 1;
        run_clks(FRAME_CLKS + 10);
        chk_eq("line0_hs_low_pixels", 32'(line0_hs_low), 32'(H_SYNC));
        chk_eq("tick_count", 32'(tick_q.size()), 32'd2);
        if (tick_q.size() >= 2) begin
            chk_eq("tick0_pos", 32'(tick_q[0] - base), 32'(FRAME_CLKS - 1));
            chk_eq("tick_gap", 32'(tick_q[1] - tick_q[0]), 32'(FRAME_CLKS));
        end

        // Run to a mid-frame point, then reset asynchronously.
        budget = 0;
        while (!(mh == 10 && mv == 4) && budget < 2 * FRAME_CLKS) begin
            run_clks(1);
            budget++;
        end
        chk_eq("reach_midframe", 32'(mh == 10 && mv == 4), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        model_reset();

        base = cyc;
        tick_q.delete();
        rgb_mode = 1;
        run_clks(2 * FRAME_CLKS + 10);
        chk_eq("post_rst_tick_count", 32'(tick_q.size()), 32'd2);
        if (tick_q.size() >= 1)
            chk_eq("post_rst_tick0_pos", 32'(tick_q[0] - base), 32'(FRAME_CLKS - 1));
        if (tick_q.size() >= 2)
            chk_eq("post_rst_tick_gap", 32'(tick_q[1] - tick_q[0]), 32'(FRAME_CLKS));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
